hex_decoder_strobe: RTL and testbench
=====================================

// Module: hex_decoder_strobe
// PURPOSE
//  Inverse of the 16x4 priority encoder: accepts 4-bit codes over a valid/ready handshake,
//  buffers them in a small FIFO and drives the matching 16-bit one-hot strobe.
//  Each strobe is held for HOLD_CYCLES enabled cycles (row/LED scan driver).
//  Sits downstream of the encoder path to regenerate one-hot selects.
// PARAMETERS
//  HOLD_CYCLES  4  enabled cycles each one-hot strobe is held; legal 1..255
//  FIFO_DEPTH   4  code buffer entries; power of 2, >=2
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_code    in   4   code to decode (0 -> out[0] ... 15 -> out[15])
//  in_valid   in   1   in_code valid
//  in_ready   out  1   FIFO can accept; transfer on in_valid && in_ready at clk edge
//  en         in   1   scan enable; low freezes hold counter and blocks new loads
//  out        out  16  one-hot strobe, all zero when idle
//  out_valid  out  1   high while out carries a strobe
//  done       out  1   one-cycle pulse during the final enabled hold cycle of a strobe
//  fifo_level out  $clog2(FIFO_DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  Reset: out=0, out_valid=0, done=0, fifo_level=0, in_ready=1 from first cycle after rst,
//   FSM=IDLE, hold counter=0. Reset mid-strobe discards FIFO contents and current strobe.
//  FIFO: in_ready = (fifo_level != FIFO_DEPTH), registered view; a push is refused when
//   full even if a pop occurs in the same cycle. Simultaneous push+pop when not full
//   keeps fifo_level unchanged. Pop only into the FSM load; never pops when empty.
//  FSM states: IDLE, HOLD (plus GAP when DECODER_GAP_EN).
//   IDLE: out=0. If en && fifo non-empty: pop, out<=16'b1<<code, cnt<=HOLD_CYCLES-1, ->HOLD.
//   HOLD: out held, out_valid=1. If !en: counter and out frozen, done=0.
//    If en && cnt!=0: cnt<=cnt-1. If en && cnt==0: done=1 this cycle, then
//    fifo non-empty -> load next code back-to-back (no zero cycle), else -> IDLE (out<=0).
//  Latency: code accepted into empty FIFO at edge N appears on out after edge N+1.
//  HOLD_CYCLES=1: new strobe every enabled cycle, done high every strobe cycle.
//  Counter width $clog2(HOLD_CYCLES+1), never wraps; exactly one bit of out set in HOLD.
//  FIFO pointers wrap modulo FIFO_DEPTH; level tracks full vs empty unambiguously.
// CONFIGURATION
//  DECODER_GAP_EN defined: after each strobe's final cycle FSM enters GAP for one
//   enabled cycle with out=0, out_valid=0 (break-before-make), then IDLE load rules apply
//   (GAP->HOLD directly if FIFO non-empty and en). Strobe period = HOLD_CYCLES+1.
//  Not defined: no GAP state; consecutive strobes back-to-back, period = HOLD_CYCLES.
// TESTING
//  1 Reset: assert rst 2 cycles mid-strobe -> out=0, out_valid=0, fifo_level=0, in_ready=1.
//  2 Single code 4'hA, HOLD=4, en=1 -> out=16'h0400 for exactly 4 cycles, done on 4th, then 0.
//  3 Push 0,5,15 back-to-back -> out 16'h0001,16'h0020,16'h8000, 4 cycles each, no gap
//    (with DECODER_GAP_EN: one zero cycle between each).
//  4 Fill FIFO with 5 pushes while en=0 -> 4 accepted, in_ready=0, fifo_level=4, 5th held.
//  5 Drop en for 3 cycles mid-HOLD of code 3 -> out=16'h0008 frozen, strobe total 4+3 cycles.
//  6 HOLD_CYCLES=1, stream codes 1..4 continuously -> one-hot changes every cycle, done high.

Source files
------------

// File: rtl/hex_decoder_strobe.sv
// hex_decoder_strobe: buffers 4-bit codes in a small FIFO and scans them out as held one-hot strobes.
// Optional break-before-make zero cycle between strobes: define DECODER_GAP_EN.
//
// state | meaning
// IDLE  | no strobe, out=0; loads the next code when en and the FIFO is non-empty
// HOLD  | strobe driven; counter steps down once per enabled cycle, done at 0
// GAP   | (DECODER_GAP_EN only) one enabled zero cycle after a strobe, then IDLE load rules
module hex_decoder_strobe #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  in_code,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        en,
  output logic [15:0]                 out,
  output logic                        out_valid,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

`ifdef DECODER_GAP_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [15:0]     out_nx;
  logic [15:0]     load_out;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, fifo_empty;

  // Full is judged on the registered level only, so a same-cycle pop never frees a slot early.
  assign in_ready   = (fifo_level != LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign push       = in_valid && in_ready;
  assign load_out   = 16'h0001 << mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      out   <= out_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = out;
    pop      = 1'b0;
    done     = 1'b0;
    case (state)
      HOLD: begin
        if (en) begin
          if (cnt != '0) begin
            cnt_nx = cnt - CW'(1);
          end else begin
            done = 1'b1;
`ifdef DECODER_GAP_EN
            state_nx = GAP;
            out_nx   = '0;
`else
            if (!fifo_empty) begin
              pop      = 1'b1;
              state_nx = HOLD;
              cnt_nx   = CNT_LOAD;
              out_nx   = load_out;
            end else begin
              state_nx = IDLE;
              out_nx   = '0;
            end
`endif
          end
        end
      end
      default: begin
        // IDLE and GAP share the load rule; GAP only exists to force one zero cycle
        if (en) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = HOLD;
            cnt_nx   = CNT_LOAD;
            out_nx   = load_out;
          end else begin
            state_nx = IDLE;
            out_nx   = '0;
          end
        end
      end
    endcase
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_hex_decoder_strobe.sv
// Bench for hex_decoder_strobe: two instances (HOLD 4 and HOLD 1) share stimulus and are
// checked every cycle against a queue-based model, plus literal directed expectations.
module tb_hex_decoder_strobe;

`ifdef DECODER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, en;
  logic [3:0]  in_code;
  logic        a_ready, a_valid, a_done, b_ready, b_valid, b_done;
  logic [15:0] a_out, b_out;
  logic [2:0]  a_level, b_level;

  hex_decoder_strobe #(.HOLD_CYCLES(4), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(a_ready),
    .en(en), .out(a_out), .out_valid(a_valid), .done(a_done), .fifo_level(a_level));

  hex_decoder_strobe #(.HOLD_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(b_ready),
    .en(en), .out(b_out), .out_valid(b_valid), .done(b_done), .fifo_level(b_level));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of buffered codes, plus the running strobe and its remaining enabled cycles.
  int hold_of [2] = '{4, 1};
  int mq   [2][16];
  int mn   [2];
  bit mact [2];
  int mcur [2];
  int mrem [2];
  bit mlive = 1'b0;

  task automatic model_cmp(input int k, input logic [15:0] o, input logic ov, input logic dn,
                           input logic [2:0] lvl, input logic rdy);
    string p;
    p = (k == 0) ? "a" : "b";
    check({p, ".out"},        32'(o),   mact[k] ? (32'h1 << mcur[k]) : 32'h0);
    check({p, ".out_valid"},  32'(ov),  32'(mact[k]));
    check({p, ".done"},       32'(dn),  32'(mact[k] && en && mrem[k] == 1));
    check({p, ".fifo_level"}, 32'(lvl), 32'(mn[k]));
    check({p, ".in_ready"},   32'(rdy), 32'(mn[k] != DEPTH));
  endtask

  task automatic model_step(input int k);
    bit take;
    if (rst) begin
      mn[k]   = 0;
      mact[k] = 1'b0;
      mrem[k] = 0;
      return;
    end
    take = in_valid && (mn[k] < DEPTH);
    if (en) begin
      if (mact[k] && mrem[k] > 1) begin
        mrem[k]--;
      end else if (mact[k] && GAP != 0) begin
        mact[k] = 1'b0;
      end else if (mn[k] > 0) begin
        mcur[k] = mq[k][0];
        for (int j = 0; j < mn[k] - 1; j++) mq[k][j] = mq[k][j+1];
        mn[k]--;
        mact[k] = 1'b1;
        mrem[k] = hold_of[k];
      end else begin
        mact[k] = 1'b0;
      end
    end
    if (take) begin
      mq[k][mn[k]] = int'(in_code);
      mn[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (mlive) begin
      model_cmp(0, a_out, a_valid, a_done, a_level, a_ready);
      model_cmp(1, b_out, b_valid, b_done, b_level, b_ready);
    end
    model_step(0);
    model_step(1);
    if (rst) mlive = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c5, c15, first, last, nz, n_on, n_done, nb, bd;
    bit drained;
    logic [15:0] seq [8];
    logic [15:0] first_v, last_v;

    rst = 1'b1; in_valid = 1'b0; in_code = 4'h0; en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset.out", 32'(a_out), 32'h0);
    check("reset.in_ready", 32'(a_ready), 32'h1);
    check("reset.level", 32'(a_level), 32'h0);

    // Test 1: reset for two cycles while a strobe is running and codes are buffered
    tick(); in_valid = 1'b1; in_code = 4'h2;
    tick(); in_code = 4'h9;
    tick(); in_code = 4'hC;
    tick(); in_valid = 1'b0;
    tick(); tick();
    check("t1.mid_out", 32'(a_out), 32'h0004);
    check("t1.mid_level", 32'(a_level), 32'h2);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("t1.out", 32'(a_out), 32'h0);
    check("t1.out_valid", 32'(a_valid), 32'h0);
    check("t1.level", 32'(a_level), 32'h0);
    check("t1.in_ready", 32'(a_ready), 32'h1);
    check("t1.b_out", 32'(b_out), 32'h0);

    // Test 2: single code A, held four cycles with done on the fourth
    tick(); in_valid = 1'b1; in_code = 4'hA;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("t2.latency_out", 32'(a_out), 32'h0);
    check("t2.latency_level", 32'(a_level), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2.out", 32'(a_out), 32'h0400);
      check("t2.done", 32'(a_done), 32'(i == 3));
    end
    @(negedge clk);
    check("t2.after_out", 32'(a_out), 32'h0);
    check("t2.after_valid", 32'(a_valid), 32'h0);
    repeat (3) tick();

    // Test 3: codes 0, 5, 15 back to back
    c0 = 0; c5 = 0; c15 = 0; first = -1; last = -1; nz = 0;
    first_v = '0; last_v = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      case (i)
        0: begin in_valid = 1'b1; in_code = 4'h0; end
        1: in_code = 4'h5;
        2: in_code = 4'hF;
        3: in_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (a_out == 16'h0001) c0++;
      if (a_out == 16'h0020) c5++;
      if (a_out == 16'h8000) c15++;
      if (a_out != 16'h0) begin
        nz++;
        if (first < 0) begin first = i; first_v = a_out; end
        last = i; last_v = a_out;
      end
    end
    check("t3.count0", 32'(c0), 32'd4);
    check("t3.count5", 32'(c5), 32'd4);
    check("t3.count15", 32'(c15), 32'd4);
    check("t3.first", 32'(first_v), 32'h0001);
    check("t3.last", 32'(last_v), 32'h8000);
    check("t3.zero_cycles", 32'(last - first + 1 - nz), 32'(2 * GAP));

    // Test 4: fill the FIFO with en low; fifth push is held off
    tick(); en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 4'(6 + i);
      tick();
    end
    tick();
    @(negedge clk);
    check("t4.level", 32'(a_level), 32'd4);
    check("t4.in_ready", 32'(a_ready), 32'h0);
    check("t4.out", 32'(a_out), 32'h0);
    check("t4.b_level", 32'(b_level), 32'd4);
    tick(); en = 1'b1;
    tick();
    @(negedge clk);
    check("t4.pop_no_push_level", 32'(a_level), 32'd3);
    check("t4.pop_ready", 32'(a_ready), 32'h1);
    check("t4.first_out", 32'(a_out), 32'h0040);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("t4.refill_level", 32'(a_level), 32'd4);
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      @(negedge clk);
      if (a_level == 3'd0 && !a_valid && b_level == 3'd0 && !b_valid) drained = 1'b1;
    end
    check("t4.drain", 32'(drained), 32'h1);

    // Test 5: en dropped for three cycles during the strobe of code 3
    tick(); in_valid = 1'b1; in_code = 4'h3;
    tick(); in_valid = 1'b0;
    tick(); en = 1'b0;
    n_on = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_out == 16'h0008) n_on++;
      if (a_done) n_done++;
      if (i < 3) check("t5.frozen_out", 32'(a_out), 32'h0008);
      if (i == 2) begin
        tick(); en = 1'b1;
      end
    end
    check("t5.strobe_cycles", 32'(n_on), 32'd7);
    check("t5.done_count", 32'(n_done), 32'd1);

    // Test 6: HOLD 1 instance fed codes 1..4 continuously
    nb = 0; bd = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 4) begin in_valid = 1'b1; in_code = 4'(i + 1); end
      else in_valid = 1'b0;
      @(negedge clk);
      if (b_out != 16'h0) begin
        if (nb < 8) seq[nb] = b_out;
        nb++;
        if (first < 0) first = i;
        last = i;
      end
      if (b_done) bd++;
    end
    check("t6.strobes", 32'(nb), 32'd4);
    check("t6.done_count", 32'(bd), 32'd4);
    check("t6.span", 32'(last - first + 1), 32'(4 + 3 * GAP));
    for (int j = 0; j < 4; j++) check("t6.order", 32'(seq[j]), 32'h1 << (j + 1));

    repeat (30) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
